video_timing_sequencer: RTL
===========================

Name: video_timing_sequencer

Overview:
- Sequences the chained 4-bit synchronous counters (LS163-style load/enable/ripple-carry) into the raster timing chain for the video section.
- Owns the horizontal and vertical pixel/line counters, the sync and blank phase state machines, and a shadowed timing-configuration register file that takes effect only at frame boundaries.
- Feeds hcount/vcount to the playfield/sprite fetch logic; sync/blank go to the video output stage.

Parameters:
- HW, 9, horizontal counter width
- VW, 9, vertical counter width
- H_TOTAL, 384, pixels per line (default active value)
- H_ACTIVE, 256, visible pixels per line
- H_SYNC_START, 288, first hcount with hsync asserted (default)
- H_SYNC_LEN, 32, hsync width in pixels
- V_TOTAL, 262, lines per frame (default)
- V_ACTIVE, 240, visible lines
- V_SYNC_START, 244, first vcount with vsync asserted (default)
- V_SYNC_LEN, 3, vsync width in lines

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pix_en  in  1  pixel clock enable; all counting advances only when high (LS163 P/T equivalent)
- cfg_wr  in  1  config write strobe, one clk
- cfg_sel  in  2  0=h_total, 1=v_total, 2=h_sync_start, 3=v_sync_start
- cfg_data  in  9  config value (upper bits ignored beyond HW/VW)
- cfg_pending  out  1  shadow differs from active, awaiting frame boundary
- hcount  out  HW  current pixel
- vcount  out  VW  current line
- hblank  out  1  high while hcount >= H_ACTIVE
- vblank  out  1  high while vcount >= V_ACTIVE
- hsync_n  out  1  active-low horizontal sync
- vsync_n  out  1  active-low vertical sync
- h_rco  out  1  horizontal ripple carry: (hcount == h_total_act-1) & pix_en
- v_rco  out  1  frame carry: h_rco & (vcount == v_total_act-1)
- frame_start  out  1  registered one-clk pulse when counters load (0,0) via wrap

Behaviour:
- Reset (async): hcount=0, vcount=0, hblank=0, vblank=0, hsync_n=1, vsync_n=1, frame_start=0, cfg_pending=0; active and shadow registers = parameter defaults; both FSMs in ACTIVE.
- pix_en low: all registers hold; h_rco/v_rco low; cfg writes still accepted.
- Horizontal, on pix_en: hcount+1; at h_total_act-1 loads 0 (synchronous load, no terminal-count overshoot).
- Vertical advances only on h_rco: vcount+1; wraps to 0 on v_rco.
- H FSM: ACTIVE -> FRONT (hcount enters H_ACTIVE) -> SYNC (enters h_sync_start_act) -> BACK (enters h_sync_start_act+H_SYNC_LEN) -> ACTIVE (wrap). V FSM identical on lines with V_* values.
- Outputs registered alongside counters; zero latency relative to hcount/vcount: hblank = state!=ACTIVE; hsync_n = 0 only in SYNC. Same for vertical.
- Sync window compared at HW+1/VW+1 bits, no wrap; if sync_start >= total, sync never asserts and the FSM goes FRONT -> ACTIVE at wrap.
- Config: cfg_wr writes shadow[cfg_sel], sets cfg_pending. Writing a total < 2 is dropped (shadow and pending unchanged).
- Apply: on the v_rco cycle all four shadow values copy to active, cfg_pending clears, and new totals govern the first line of the new frame.
- cfg_wr coincident with v_rco: the applied set excludes the new write; shadow updates and cfg_pending stays 1.
- frame_start asserts the clk after the v_rco cycle, exactly once per frame.
- Reset mid-line/mid-frame: immediate return to reset values; pending configuration is discarded.

Test Plan:
- Reset, then reset release with pix_en=0 for 10 clks -> hcount=0, vcount=0, hsync_n=1, vsync_n=1, blanks 0, no h_rco.
- pix_en=1 for one line -> hblank high for hcount 256..383; hsync_n low for 288..319; h_rco single pulse at hcount=383; vcount 0 -> 1.
- Run a full frame -> vblank lines 240..261; vsync_n low lines 244..246; v_rco at (383,261); frame_start one clk later; 262*384 enabled clocks per frame.
- pix_en toggling 1/0 every clk -> counters advance only on enabled clocks; line length 384 enables; h_rco never high while pix_en=0.
- Mid-frame cfg_wr sel=0 data=320 -> cfg_pending=1, current frame keeps 384; after v_rco h_rco occurs at hcount=319; pending=0. Write data=1 -> ignored.
- cfg_wr sel=1 data=250 on the v_rco cycle -> next frame still 262 lines, pending=1; following frame 250 lines. Assert reset mid-line -> all outputs at reset values immediately.

Source files
------------

// File: rtl/video_timing_sequencer.sv
// Raster timing chain: LS163-style horizontal/vertical counters, sync/blank phase FSMs,
// and a shadowed timing configuration that is applied only at frame wrap.
module video_timing_sequencer #(
  parameter int HW           = 9,
  parameter int VW           = 9,
  parameter int H_TOTAL      = 384,
  parameter int H_ACTIVE     = 256,
  parameter int H_SYNC_START = 288,
  parameter int H_SYNC_LEN   = 32,
  parameter int V_TOTAL      = 262,
  parameter int V_ACTIVE     = 240,
  parameter int V_SYNC_START = 244,
  parameter int V_SYNC_LEN   = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_en,
  input  logic          cfg_wr,
  input  logic [1:0]    cfg_sel,
  input  logic [8:0]    cfg_data,
  output logic          cfg_pending,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          hblank,
  output logic          vblank,
  output logic          hsync_n,
  output logic          vsync_n,
  output logic          h_rco,
  output logic          v_rco,
  output logic          frame_start
);

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_t;

  localparam logic [HW-1:0] LP_H_ONE    = HW'(1);
  localparam logic [HW-1:0] LP_H_TWO    = HW'(2);
  localparam logic [VW-1:0] LP_V_ONE    = VW'(1);
  localparam logic [VW-1:0] LP_V_TWO    = VW'(2);
  localparam logic [HW:0]   LP_H_ACTIVE = (HW+1)'(H_ACTIVE);
  localparam logic [VW:0]   LP_V_ACTIVE = (VW+1)'(V_ACTIVE);
  localparam logic [HW:0]   LP_H_SLEN   = (HW+1)'(H_SYNC_LEN);
  localparam logic [VW:0]   LP_V_SLEN   = (VW+1)'(V_SYNC_LEN);

  // Wrap always returns to ACTIVE; otherwise a phase advances only when the count enters its boundary.
  function automatic phase_t next_phase(input phase_t cur, input logic wrap,
                                        input logic hit_act, input logic hit_sync,
                                        input logic hit_back);
    phase_t nxt;
    nxt = cur;
    if (wrap) begin
      nxt = PH_ACTIVE;
    end else begin
      case (cur)
        PH_ACTIVE: begin
          if (hit_act) nxt = hit_sync ? PH_SYNC : PH_FRONT;
          else         nxt = PH_ACTIVE;
        end
        PH_FRONT: begin
          if (hit_sync) nxt = PH_SYNC;
          else          nxt = PH_FRONT;
        end
        PH_SYNC: begin
          if (hit_back) nxt = PH_BACK;
          else          nxt = PH_SYNC;
        end
        PH_BACK: nxt = PH_BACK;
        default: nxt = PH_ACTIVE;
      endcase
    end
    return nxt;
  endfunction

  logic [HW-1:0] r_hcount, r_h_total_act, r_h_ss_act, r_h_total_sh, r_h_ss_sh;
  logic [VW-1:0] r_vcount, r_v_total_act, r_v_ss_act, r_v_total_sh, r_v_ss_sh;
  phase_t        r_h_phase, r_v_phase;
  logic          r_hblank, r_vblank, r_hsync_n, r_vsync_n, r_frame_start, r_cfg_pending;

  logic          w_h_last, w_v_last, w_h_rco, w_v_rco, w_cfg_ok;
  logic [HW-1:0] w_h_next, w_cfg_h;
  logic [VW-1:0] w_v_next, w_cfg_v;
  logic [HW:0]   w_h_next_x, w_h_ss_x, w_h_sync_end;
  logic [VW:0]   w_v_next_x, w_v_ss_x, w_v_sync_end;
  phase_t        w_h_phase_nxt, w_v_phase_nxt;

  assign w_h_last = (r_hcount == (r_h_total_act - LP_H_ONE));
  assign w_v_last = (r_vcount == (r_v_total_act - LP_V_ONE));
  assign w_h_rco  = pix_en & w_h_last;
  assign w_v_rco  = w_h_rco & w_v_last;
  assign w_h_next = w_h_last ? '0 : (r_hcount + LP_H_ONE);
  assign w_v_next = w_v_last ? '0 : (r_vcount + LP_V_ONE);

  // Sync window is evaluated one bit wider so start+len never aliases back into the line.
  assign w_h_next_x   = {1'b0, w_h_next};
  assign w_h_ss_x     = {1'b0, r_h_ss_act};
  assign w_h_sync_end = w_h_ss_x + LP_H_SLEN;
  assign w_v_next_x   = {1'b0, w_v_next};
  assign w_v_ss_x     = {1'b0, r_v_ss_act};
  assign w_v_sync_end = w_v_ss_x + LP_V_SLEN;

  assign w_h_phase_nxt = next_phase(r_h_phase, w_h_last, (w_h_next_x == LP_H_ACTIVE),
                                    (w_h_next_x == w_h_ss_x), (w_h_next_x == w_h_sync_end));
  assign w_v_phase_nxt = next_phase(r_v_phase, w_v_last, (w_v_next_x == LP_V_ACTIVE),
                                    (w_v_next_x == w_v_ss_x), (w_v_next_x == w_v_sync_end));

  assign w_cfg_h  = HW'(cfg_data);
  assign w_cfg_v  = VW'(cfg_data);
  assign w_cfg_ok = cfg_wr & ~(((cfg_sel == 2'd0) && (w_cfg_h < LP_H_TWO)) ||
                               ((cfg_sel == 2'd1) && (w_cfg_v < LP_V_TWO)));

  // Pixel/line counters and the frame-start pulse that follows the frame carry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_v_rco;
      if (pix_en)  r_hcount <= w_h_next;
      if (w_h_rco) r_vcount <= w_v_next;
    end
  end

  // Shadow register file; the whole set moves to active on the frame carry, before any same-cycle write lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h_total_act <= HW'(H_TOTAL);
      r_v_total_act <= VW'(V_TOTAL);
      r_h_ss_act    <= HW'(H_SYNC_START);
      r_v_ss_act    <= VW'(V_SYNC_START);
      r_h_total_sh  <= HW'(H_TOTAL);
      r_v_total_sh  <= VW'(V_TOTAL);
      r_h_ss_sh     <= HW'(H_SYNC_START);
      r_v_ss_sh     <= VW'(V_SYNC_START);
      r_cfg_pending <= 1'b0;
    end else begin
      if (w_cfg_ok) begin
        case (cfg_sel)
          2'd0:    r_h_total_sh <= w_cfg_h;
          2'd1:    r_v_total_sh <= w_cfg_v;
          2'd2:    r_h_ss_sh    <= w_cfg_h;
          2'd3:    r_v_ss_sh    <= w_cfg_v;
          default: r_h_total_sh <= r_h_total_sh;
        endcase
      end
      if (w_v_rco) begin
        r_h_total_act <= r_h_total_sh;
        r_v_total_act <= r_v_total_sh;
        r_h_ss_act    <= r_h_ss_sh;
        r_v_ss_act    <= r_v_ss_sh;
        r_cfg_pending <= w_cfg_ok;
      end else if (w_cfg_ok) begin
        r_cfg_pending <= 1'b1;
      end
    end
  end

  // Horizontal phase FSM; blank/sync register together with hcount so they carry no extra latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h_phase <= PH_ACTIVE;
      r_hblank  <= 1'b0;
      r_hsync_n <= 1'b1;
    end else if (pix_en) begin
      r_h_phase <= w_h_phase_nxt;
      r_hblank  <= (w_h_phase_nxt != PH_ACTIVE);
      r_hsync_n <= (w_h_phase_nxt != PH_SYNC);
    end
  end

  // Vertical phase FSM, stepped once per line on the horizontal carry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v_phase <= PH_ACTIVE;
      r_vblank  <= 1'b0;
      r_vsync_n <= 1'b1;
    end else if (w_h_rco) begin
      r_v_phase <= w_v_phase_nxt;
      r_vblank  <= (w_v_phase_nxt != PH_ACTIVE);
      r_vsync_n <= (w_v_phase_nxt != PH_SYNC);
    end
  end

  assign hcount      = r_hcount;
  assign vcount      = r_vcount;
  assign hblank      = r_hblank;
  assign vblank      = r_vblank;
  assign hsync_n     = r_hsync_n;
  assign vsync_n     = r_vsync_n;
  assign h_rco       = w_h_rco;
  assign v_rco       = w_v_rco;
  assign frame_start = r_frame_start;
  assign cfg_pending = r_cfg_pending;

endmodule
